// File: rtl/demux_1_to_16_reg.sv
// demux_1_to_16_reg: registered 1-to-16 demultiplexer with per-channel
// valid/ack handshake.
//
// Each of the 16 output channels holds one word. A channel is filled by an
// accepted transfer and drained by its ack. An ack and a transfer may hit the
// same channel in the same cycle.
//
// Optional build macro: DEMUX_AUTO_SEL_EN
//   defined   -> the destination comes from an internal 4-bit counter that
//                advances on every accepted transfer; the sel port is ignored
//   undefined -> the destination is the sel port
//
// Ports:
//   clk      in   clock, rising-edge active
//   rst      in   asynchronous active-high reset
//   a        in   W-bit data word to distribute
//   a_valid  in   a holds a word to transfer
//   a_ready  out  combinational: the word can be accepted this cycle
//   sel      in   4-bit destination channel (unused in auto mode)
//   z        out  16*W bits, registered; channel k is z[k*W +: W]
//   z_valid  out  16 bits, registered; bit k = channel k holds an unconsumed word
//   z_ack    in   16 bits; bit k consumes channel k
//   sel_cur  out  combinational: effective destination this cycle
module demux_1_to_16_reg #(
    parameter int INPUT_BIT_LENGTH = 1,
    localparam int unsigned W = (INPUT_BIT_LENGTH < 1) ? 1 : INPUT_BIT_LENGTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    a,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [3:0]      sel,
    output logic [16*W-1:0] z,
    output logic [15:0]     z_valid,
    input  logic [15:0]     z_ack,
    output logic [3:0]      sel_cur
);

    logic [3:0] s;
    logic       xfer;

`ifdef DEMUX_AUTO_SEL_EN
    // Destination counter; advances only on an accepted transfer.
    logic [3:0] cnt;
    logic       unused_sel;

    assign unused_sel = ^sel;
    assign s          = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (xfer) begin
            cnt <= cnt + 4'd1;
        end
    end
`else
    assign s = sel;
`endif

    assign sel_cur = s;
    // A full channel can still accept when it is being acked in this cycle.
    assign a_ready = ~z_valid[s] | z_ack[s];
    assign xfer    = a_valid & a_ready;

    // Channel storage and valid flags. Acks on empty channels are harmless
    // because clearing an already-clear bit changes nothing; a same-cycle
    // transfer overrides the ack on its channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z       <= '0;
            z_valid <= '0;
        end else begin
            z_valid <= z_valid & ~z_ack;
            if (xfer) begin
                z_valid[s] <= 1'b1;
            end
            for (int k = 0; k < 16; k++) begin
                if (xfer && (s == 4'(k))) begin
                    z[k*W +: W] <= a;
                end
            end
        end
    end

endmodule

// File: doc/demux_1_to_16_reg.md
DEMUX_1_TO_16_REG -- requirements
Module: demux_1_to_16_reg

Interface
REQ-001 The module SHALL have parameter INPUT_BIT_LENGTH, default 1, giving the data width per channel; values below 1 SHALL be treated as 1 (W = max(INPUT_BIT_LENGTH,1)).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port a, input, W bits: data word to distribute.
REQ-005 The module SHALL have port a_valid, input, 1 bit: a holds a word to transfer.
REQ-006 The module SHALL have port a_ready, output, 1 bit: the word can be accepted this cycle.
REQ-007 The module SHALL have port sel, input, 4 bits: destination channel 0..15.
REQ-008 The module SHALL have port z, output, 16*W bits: channel k data is z[k*W +: W].
REQ-009 The module SHALL have port z_valid, output, 16 bits: bit k set means channel k holds an unconsumed word.
REQ-010 The module SHALL have port z_ack, input, 16 bits: bit k consumes channel k.
REQ-011 The module SHALL have port sel_cur, output, 4 bits: the effective destination for the current cycle.

Function
REQ-012 The effective select s SHALL be sel, or the auto counter when REQ-024 applies; sel_cur SHALL equal s combinationally.
REQ-013 a_ready SHALL be combinational: ~z_valid[s] | z_ack[s].
REQ-014 A transfer SHALL occur only when a_valid & a_ready is high; sel and a SHALL be sampled only in that cycle.
REQ-015 On a transfer, channel s data SHALL equal a and z_valid[s] SHALL be 1 from the next cycle (latency 1).
REQ-016 Channel data SHALL hold its value until the next transfer to that channel; z_ack SHALL never clear data.
REQ-017 When z_ack[k] is high and z_valid[k] is 1, z_valid[k] SHALL be 0 next cycle, unless a transfer to k occurs in the same cycle.
REQ-018 When an ack and a transfer hit the same channel in the same cycle, z_valid SHALL stay 1 and the data SHALL be replaced by the new word.
REQ-019 z_ack[k] while z_valid[k] is 0 SHALL be ignored.
REQ-020 Transfers to one channel SHALL never modify data or z_valid of any other channel; acks to several channels in one cycle SHALL all take effect.
REQ-021 When a_valid is high and channel s is full with no ack, a_ready SHALL be 0 and no state SHALL change; a and s must stay stable until acceptance.

Reset
REQ-022 While rst is high, all channel data, z_valid and the auto counter SHALL be 0 immediately, regardless of clk; a_ready SHALL therefore be 1 and sel_cur SHALL be sel, or 0 in auto mode.
REQ-023 Asserting rst mid-operation SHALL discard all held words; the first rising clk edge after rst falls SHALL already be able to accept a transfer.

Configuration
REQ-024 When macro DEMUX_AUTO_SEL_EN is defined, s SHALL come from an internal 4-bit counter; the sel port SHALL be ignored; the counter SHALL advance by 1 only on a transfer and SHALL wrap from 15 to 0.
REQ-025 When DEMUX_AUTO_SEL_EN is not defined, no counter SHALL exist and s SHALL equal sel.

Verification
REQ-026 With W=8, after reset: assert a=0x5A, sel=3, a_valid for one cycle -> next cycle z_valid=0x0008 and channel 3 = 0x5A; all other channels = 0.
REQ-027 With channel 3 full: a=0x11, sel=3, a_valid, no ack -> a_ready=0 and channel 3 stays 0x5A; then assert z_ack[3] -> same cycle a_ready=1, next cycle channel 3 = 0x11 and z_valid[3]=1.
REQ-028 With channels 0, 5 and 15 full: z_ack=0x8021 for one cycle -> next cycle z_valid=0x0000 and data unchanged.
REQ-029 Fill channel 7, then assert rst asynchronously between clock edges -> z_valid=0 and z=0 before the next edge, and a_ready=1.
REQ-030 With DEMUX_AUTO_SEL_EN defined: make 17 transfers of values 0..16, acking each channel one cycle after it fills -> channels 0..15 receive 0..15, channel 0 then receives 16, sel_cur=1 at the end, and the sel port has no effect.
